serial_deserializer: RTL
========================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the assembled word width; legal values are 2 and above.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port din, input, 1 bit: serial data bit.
REQ-005 SHALL have port din_valid, input, 1 bit: din carries a bit this cycle.
REQ-006 SHALL have port din_ready, output, 1 bit: the block can accept a bit this cycle.
REQ-007 SHALL have port dout, output, DATA_WIDTH bits: the assembled word, fed to the downstream bit-reverse stage.
REQ-008 SHALL have port dout_valid, output, 1 bit: dout holds a complete word.
REQ-009 SHALL have port dout_ready, input, 1 bit: downstream accepts dout this cycle.
REQ-010 SHALL have port parity_err, output, 1 bit: parity-check result for the word on dout.

Function
REQ-011 SHALL accept a bit only on a cycle where din_valid and din_ready are both high.
REQ-012 SHALL pack bits LSB-first: the k-th accepted bit of a word (k = 0..DATA_WIDTH-1) becomes dout[k].
REQ-013 SHALL track position with a counter 0..DATA_WIDTH-1 that wraps to 0 after the final data bit (or after the parity bit in parity mode).
REQ-014 SHALL load the completed word into the output slot and assert dout_valid on the edge that accepts the word's final bit, giving 1-cycle latency.
REQ-015 SHALL complete a word transfer on any cycle where dout_valid and dout_ready are both high; dout_valid then falls on the next edge unless a new word loads on the same edge.
REQ-016 SHALL hold dout and parity_err stable while dout_valid is high and dout_ready is low.
REQ-017 SHALL drive din_ready low only when the next accepted bit would complete a word while dout_valid is high and dout_ready is low; otherwise din_ready is high.
REQ-018 SHALL sustain back-to-back words with no bubble cycles when dout_ready stays high.
REQ-019 SHALL treat din_valid gaps of any length as neutral: the counter and partial word are kept unchanged.
REQ-020 SHALL drive parity_err to 0 whenever DESER_PARITY_EN is not defined.

Reset
REQ-021 SHALL, when reset is asserted, immediately force the counter to 0, the partial word to 0, dout to 0, dout_valid to 0, parity_err to 0, and the FSM to COLLECT.
REQ-022 SHALL discard any partial word on reset mid-word; the first bit accepted after reset deasserts is bit 0 of a new word.

Configuration
REQ-023 SHALL, when macro DESER_PARITY_EN is defined, add FSM state PARITY after COLLECT: after DATA_WIDTH data bits, one extra parity bit is accepted (even parity, XOR of data bits and parity bit equals 0); word load and the REQ-017 stall move to the parity bit; parity_err is 1 on mismatch and is loaded with the word.
REQ-024 SHALL, without DESER_PARITY_EN, use the single state COLLECT with a word length of exactly DATA_WIDTH bits.

Structure
REQ-025 SHALL take the FSM state enum (COLLECT, PARITY) and the counter-width function ($clog2-based) from shared package deser_pkg.
REQ-026 SHALL implement the output slot (dout, dout_valid, parity_err, and the REQ-015/016 behaviour) as sub-module deser_out_slot.

Verification (DATA_WIDTH=8)
REQ-027 Bench SHALL cover: bits 1,0,1,0,0,1,0,1 with dout_ready=1 -> dout=0xA5, dout_valid high for 1 cycle, starting the cycle after the 8th bit.
REQ-028 Bench SHALL cover: 0x01 then 0x80 with din_valid held high -> two dout_valid pulses exactly 8 cycles apart, dout=0x01 then 0x80.
REQ-029 Bench SHALL cover: 0x3C sent with dout_ready=0, then 0xC3 sent -> din_ready low after 7 bits of 0xC3 and dout held at 0x3C; raising dout_ready -> 0x3C taken, then 0xC3 valid on the next cycle.
REQ-030 Bench SHALL cover: 0x5A sent with random din_valid gaps -> dout=0x5A.
REQ-031 Bench SHALL cover: reset pulse after 4 bits, then 0xFF sent -> dout_valid 0 during reset, then dout=0xFF.
REQ-032 Bench SHALL cover, with DESER_PARITY_EN defined: 0x07 plus parity bit 1 -> parity_err=0; 0x07 plus parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial deserializer.
package deser_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/deser_out_slot.sv
// Single-entry output holding register with valid/ready handshake.
module deser_out_slot
  import deser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  perr,
  input  logic                  dout_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  parity_err
);

  // A load may coincide with a completed transfer; the new word wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
    end else if (load) begin
      dout       <= word;
      dout_valid <= 1'b1;
      parity_err <= perr;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel converter with a one-word output slot.
// Define DESER_PARITY_EN to append an even-parity bit to every word.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  parity_err
);

  localparam int unsigned    CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] word;
  logic                  accept, last_bit, completing, load, perr;

  assign accept    = din_valid && din_ready;
  assign last_bit  = (cnt_q == LAST_IDX);
  // Stall only the word-completing bit, and only if the slot cannot drain.
  assign din_ready = !(completing && dout_valid && !dout_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    completing = 1'b0;
    load       = 1'b0;
    perr       = 1'b0;
    word       = shreg_q;
`ifdef DESER_PARITY_EN
    case (state_q)
      COLLECT: begin
        if (accept && last_bit) state_d = PARITY;
      end
      PARITY: begin
        completing = 1'b1;
        if (accept) begin
          load    = 1'b1;
          perr    = (^shreg_q) ^ din;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
`else
    state_d     = COLLECT;
    completing  = (state_q == COLLECT) && last_bit;
    load        = accept && completing;
    word[cnt_q] = din;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      if (accept && state_q == COLLECT) begin
        shreg_q[cnt_q] <= din;
        cnt_q          <= last_bit ? '0 : cnt_q + CW'(1);
      end
      if (load) shreg_q <= '0;
    end
  end

  deser_out_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .word       (word),
    .perr       (perr),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .parity_err (parity_err)
  );

endmodule
